led_pattern_ctrl: RTL and testbench
===================================

LED_PATTERN_CTRL -- requirements
Module: led_pattern_ctrl

Interface
REQ-001 SHALL have parameter T_TICK, default 12500000, base tick period in CLK cycles (250 ms at 50 MHz); legal range 2..2^26.
REQ-002 SHALL have port CLK  input  1  system clock; all state rising-edge triggered.
REQ-003 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port KEY  input  1  mode-advance button, asynchronous to CLK, level, active-high.
REQ-005 SHALL have port SPEED  input  2  step divisor select; step every 2^SPEED base ticks.
REQ-006 SHALL have port LED  output  4  LED pattern, registered.
REQ-007 SHALL have port MODE  output  2  current mode, registered: 0 COUNT, 1 CHASE, 2 BOUNCE, 3 BLINK.
REQ-008 SHALL have port TICK  output  1  one-cycle pulse, high in the cycle whose closing edge updates LED by a step.

Function
REQ-009 SHALL run a 26-bit prescaler counting 0..T_TICK-1 and wrapping to 0; base tick is high in the cycle where the prescaler equals T_TICK-1.
REQ-010 SHALL run a 3-bit step counter that advances on each base tick.
REQ-011 On a base tick with step counter >= 2^SPEED-1, TICK SHALL be high, and the step counter SHALL clear to 0.
REQ-012 SPEED SHALL be sampled live; if the step counter already exceeds the new limit, the next base tick SHALL produce a step.
REQ-013 KEY SHALL pass through a two-flop synchronizer and a third delay flop; the key event is sync2 & ~sync3, one cycle wide per rising edge.
REQ-014 A KEY rising edge set up before edge n SHALL change MODE at edge n+2.
REQ-015 A key event SHALL advance MODE modulo 4 (BLINK -> COUNT).
REQ-016 A key event SHALL load LED with the new mode's initial pattern: COUNT 0000, CHASE 0001, BOUNCE 0001 with direction up, BLINK 0000.
REQ-017 A key event SHALL clear the prescaler and the step counter.
REQ-018 If a key event and a step coincide, the key event SHALL win; TICK SHALL be forced low that cycle and no step applied.
REQ-019 On each step, COUNT SHALL set LED to LED+1 modulo 16 (1111 -> 0000).
REQ-020 On each step, CHASE SHALL rotate LED left by one (1000 -> 0001).
REQ-021 On each step, BOUNCE SHALL shift LED toward bit 3 while the direction is up.
REQ-022 In BOUNCE, on reaching 1000 the direction SHALL flip to down, and on reaching 0001 it SHALL flip to up; sequence 0001,0010,0100,1000,0100,0010,0001,0010...
REQ-023 In BLINK, each step SHALL invert all four LEDs.
REQ-024 LED SHALL hold between steps; MODE SHALL hold between key events.
REQ-025 Held KEY SHALL produce exactly one event; KEY pulses shorter than one CLK period need not be detected.

Reset
REQ-026 RST high SHALL immediately force LED=0000, MODE=0 (COUNT), TICK=0, the prescaler and step counter to 0, BOUNCE direction up and all synchronizer flops to 0, independent of CLK.
REQ-027 After RST deasserts, the first step SHALL occur T_TICK*2^SPEED cycles later.
REQ-028 RST asserted mid-step or mid-key-sync SHALL discard the pending event.
REQ-029 A KEY held high through reset release SHALL generate one key event after release.

Verification (T_TICK=4 for simulation)
REQ-030 Reset release, SPEED=0, KEY=0 -> TICK every 4 cycles; LED 0001,0010,...,1111,0000 across 16 steps.
REQ-031 SPEED=3 -> TICK every 32 cycles; change to SPEED=0 with step counter=5 -> step on the next base tick.
REQ-032 KEY pulse of 3 cycles -> MODE 0->1 exactly 2 edges after the rise, LED=0001, then 0010,0100,1000,0001 on steps.
REQ-033 Three KEY pulses (BOUNCE then BLINK) -> BOUNCE sequence as in REQ-022 including both direction flips; BLINK gives 0000,1111,0000.
REQ-034 Key event in the same cycle as a step -> TICK low, LED = new initial pattern, next step T_TICK*2^SPEED cycles later; fourth press wraps MODE 3->0.
REQ-035 RST pulsed asynchronously between edges while in CHASE -> LED=0000 and MODE=0 before the next CLK edge.

Source files
------------

// File: rtl/led_pattern_ctrl.sv
// LED pattern controller: prescaled step timebase, synchronised mode-advance key and
// four animated LED patterns (count, chase, bounce, blink).
module led_pattern_ctrl #(
   parameter int unsigned T_TICK = 12500000
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       KEY,
   input  logic [1:0] SPEED,
   output logic [3:0] LED,
   output logic [1:0] MODE,
   output logic       TICK
);

   typedef enum logic [1:0] {
      ModeCount  = 2'd0,
      ModeChase  = 2'd1,
      ModeBounce = 2'd2,
      ModeBlink  = 2'd3
   } mode_e;

   localparam logic [25:0] PRESC_MAX = 26'(T_TICK - 1);

   mode_e       r_mode;
   mode_e       w_mode_nxt;
   logic [3:0]  r_led;
   logic [3:0]  w_led_nxt;
   logic        r_dir_down;
   logic        w_dir_down_nxt;
   logic [25:0] r_presc;
   logic [25:0] w_presc_nxt;
   logic [2:0]  r_step_cnt;
   logic [2:0]  w_step_cnt_nxt;
   logic        r_sync1;
   logic        r_sync2;
   logic        r_sync3;
   logic        w_key_evt;
   logic        w_base_tick;
   logic        w_step;
   logic [2:0]  w_step_limit;

   // Key synchroniser plus one delay flop for rising-edge detection
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_sync3 <= 1'b0;
      end else begin
         r_sync1 <= KEY;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
      end
   end

   assign w_key_evt   = r_sync2 & ~r_sync3;
   assign w_base_tick = (r_presc == PRESC_MAX);

   always_comb begin
      w_step_limit = 3'd0;
      unique case (SPEED)
         2'd0:    w_step_limit = 3'd0;
         2'd1:    w_step_limit = 3'd1;
         2'd2:    w_step_limit = 3'd3;
         default: w_step_limit = 3'd7;
      endcase
   end

   // >= rather than == so a live SPEED drop below the current count steps at once
   assign w_step = w_base_tick & (r_step_cnt >= w_step_limit) & ~w_key_evt;

   always_comb begin
      w_presc_nxt    = r_presc + 26'd1;
      w_step_cnt_nxt = r_step_cnt;
      if (w_base_tick) begin
         w_presc_nxt    = 26'd0;
         w_step_cnt_nxt = (r_step_cnt >= w_step_limit) ? 3'd0 : r_step_cnt + 3'd1;
      end
      if (w_key_evt) begin
         w_presc_nxt    = 26'd0;
         w_step_cnt_nxt = 3'd0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_presc    <= 26'd0;
         r_step_cnt <= 3'd0;
      end else begin
         r_presc    <= w_presc_nxt;
         r_step_cnt <= w_step_cnt_nxt;
      end
   end

   // Mode FSM: state register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_mode <= ModeCount;
      end else begin
         r_mode <= w_mode_nxt;
      end
   end

   // Mode FSM: next state
   always_comb begin
      w_mode_nxt = r_mode;
      if (w_key_evt) begin
         w_mode_nxt = mode_e'(r_mode + 2'd1);
      end
   end

   // Mode FSM: outputs
   always_comb begin
      MODE = r_mode;
      LED  = r_led;
      TICK = w_step;
   end

   always_comb begin
      w_led_nxt      = r_led;
      w_dir_down_nxt = r_dir_down;
      if (w_key_evt) begin
         w_dir_down_nxt = 1'b0;
         w_led_nxt      = ((w_mode_nxt == ModeChase) || (w_mode_nxt == ModeBounce)) ?
                          4'b0001 : 4'b0000;
      end else if (w_step) begin
         unique case (r_mode)
            ModeCount: w_led_nxt = r_led + 4'd1;
            ModeChase: w_led_nxt = {r_led[2:0], r_led[3]};
            ModeBounce: begin
               if (!r_dir_down) begin
                  w_led_nxt = {r_led[2:0], 1'b0};
                  if (w_led_nxt == 4'b1000) w_dir_down_nxt = 1'b1;
               end else begin
                  w_led_nxt = {1'b0, r_led[3:1]};
                  if (w_led_nxt == 4'b0001) w_dir_down_nxt = 1'b0;
               end
            end
            default: w_led_nxt = ~r_led;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_led      <= 4'b0000;
         r_dir_down <= 1'b0;
      end else begin
         r_led      <= w_led_nxt;
         r_dir_down <= w_dir_down_nxt;
      end
   end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed plus randomised bench for led_pattern_ctrl against a cycle-level behavioural model.
module tb_led_pattern_ctrl;

   localparam int unsigned TT = 4;

   logic       CLK = 1'b0;
   logic       RST;
   logic       KEY;
   logic [1:0] SPEED;
   logic [3:0] LED;
   logic [1:0] MODE;
   logic       TICK;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   led_pattern_ctrl #(.T_TICK(TT)) dut (
      .CLK   (CLK),
      .RST   (RST),
      .KEY   (KEY),
      .SPEED (SPEED),
      .LED   (LED),
      .MODE  (MODE),
      .TICK  (TICK)
   );

   // Model: cycles since last restart, base ticks since last step, KEY samples per edge
   int m_mode;
   int m_led;
   int m_bidx;
   int m_cyc;
   int m_bases;
   bit k1, k2, k3;
   int bounce_seq [6] = '{1, 2, 4, 8, 4, 2};

   function automatic bit m_event();
      return k2 && !k3;
   endfunction

   function automatic bit m_base();
      return (m_cyc % TT) == (TT - 1);
   endfunction

   function automatic bit m_step_due();
      return m_base() && (m_bases >= (1 << SPEED) - 1);
   endfunction

   function automatic bit m_tick();
      return m_step_due() && !m_event();
   endfunction

   task automatic model_reset();
      m_mode = 0; m_led = 0; m_bidx = 0; m_cyc = 0; m_bases = 0;
      k1 = 0; k2 = 0; k3 = 0;
   endtask

   task automatic model_advance();
      if (m_event()) begin
         m_mode  = (m_mode + 1) % 4;
         m_led   = (m_mode == 1 || m_mode == 2) ? 1 : 0;
         m_bidx  = 0;
         m_cyc   = 0;
         m_bases = 0;
      end else begin
         if (m_step_due()) begin
            case (m_mode)
               0: m_led = (m_led + 1) % 16;
               1: m_led = ((m_led << 1) | (m_led >> 3)) & 15;
               2: begin
                  m_bidx = (m_bidx + 1) % 6;
                  m_led  = bounce_seq[m_bidx];
               end
               default: m_led = m_led ^ 15;
            endcase
            m_bases = 0;
         end else if (m_base()) begin
            m_bases++;
         end
         m_cyc++;
      end
      k3 = k2; k2 = k1; k1 = KEY;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   // Compare at the falling edge, then advance the model across the rising edge
   task automatic cyc();
      @(negedge CLK);
      check("led", 32'(LED), 32'(m_led));
      check("mode", 32'(MODE), 32'(m_mode));
      check("tick", 32'(TICK), RST ? 32'd0 : 32'(m_tick()));
      if (RST) model_reset();
      else     model_advance();
      @(posedge CLK);
      #1;
   endtask

   task automatic press();
      KEY = 1'b1;
      repeat (2) cyc();
      KEY = 1'b0;
   endtask

   initial begin
      RST = 1'b1; KEY = 1'b0; SPEED = 2'd0;
      model_reset();
      repeat (2) cyc();
      RST = 1'b0;

      // Count mode at full rate: 16+ steps
      repeat (70) cyc();

      // Slowest rate, then drop SPEED while the step counter sits at 5
      SPEED = 2'd3;
      repeat (75) cyc();
      for (int i = 0; i < 40 && m_bases != 5; i++) cyc();
      check("bases_reached_5", 32'(m_bases), 32'd5);
      SPEED = 2'd0;
      repeat (10) cyc();

      // Three-cycle key pulse into CHASE
      KEY = 1'b1;
      repeat (3) cyc();
      KEY = 1'b0;
      repeat (25) cyc();

      // BOUNCE with both flips, then BLINK
      press();
      repeat (30) cyc();
      press();
      repeat (12) cyc();

      // Presses at every phase of the step period; one coincides with a step
      for (int ph = 0; ph < 4; ph++) begin
         repeat (ph) cyc();
         press();
         repeat (10) cyc();
      end
      SPEED = 2'd1;
      for (int ph = 0; ph < 8; ph++) begin
         repeat (ph) cyc();
         press();
         repeat (12) cyc();
      end

      // Randomised key activity and live SPEED changes
      repeat (800) begin
         if ($urandom_range(0, 15) == 0) KEY = ~KEY;
         if ($urandom_range(0, 63) == 0) SPEED = 2'($urandom_range(0, 3));
         cyc();
      end
      KEY = 1'b0; SPEED = 2'd0;
      repeat (4) cyc();

      // Reach CHASE, then reset asynchronously between edges
      for (int i = 0; i < 4 && m_mode != 1; i++) begin
         press();
         repeat (3) cyc();
      end
      repeat (9) cyc();
      #2 RST = 1'b1;
      #1;
      check("async_led", 32'(LED), 32'd0);
      check("async_mode", 32'(MODE), 32'd0);
      check("async_tick", 32'(TICK), 32'd0);
      model_reset();
      repeat (2) cyc();

      // KEY held through reset release gives exactly one event
      KEY = 1'b1;
      cyc();
      RST = 1'b0;
      repeat (20) cyc();
      KEY = 1'b0;
      repeat (20) cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
